// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multi-digit seven-segment scan driver.
package seg_scan_pkg;

    localparam int DIGIT_W   = 3;
    localparam int MAX_DIG   = 32;
    localparam int MAX_VEC_W = DIGIT_W * MAX_DIG;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    // Callers zero-extend their packed digit vector to MAX_VEC_W bits.
    function automatic logic [DIGIT_W-1:0] digit_at(input logic [MAX_VEC_W-1:0] vec,
                                                    input int unsigned i);
        return vec[i*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter: one slot is PRESCALE cycles, the first BLANK_CYC of them blanked.
module scan_prescaler #(
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic blank_end,
    output logic slot_end
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    assign blank_end = run && (count == BLANK_LAST);
    assign slot_end  = run && (count == SLOT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= slot_end ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes NDIG digits onto one decoder input with blanked, active-low anode slots.
// Handshake: load is a one-cycle strobe with no ready; it is always accepted on the edge it is high.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [NDIG*DIGIT_W-1:0]   load_data,
    output logic [DIGIT_W-1:0]        digit_code,
    output logic [NDIG-1:0]           anode_n,
    output logic                      blank,
    output logic                      frame_done
);

    localparam int IW = $clog2(NDIG);
    localparam int VW = NDIG * DIGIT_W;
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    scan_state_t     state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [VW-1:0]   active, active_nxt;
    logic [VW-1:0]   pending, pending_nxt;
    logic            pending_valid, pending_valid_nxt;
    logic            frame_edge;
    logic            blank_end, slot_end;
    logic            show_nxt;
    logic [NDIG-1:0] sel_onehot;

    scan_prescaler #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clear     (!enable || (state == IDLE)),
        .run       (enable && (state != IDLE)),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    always_comb begin
        state_nxt         = state;
        idx_nxt           = idx;
        active_nxt        = active;
        pending_nxt       = pending;
        pending_valid_nxt = pending_valid;
        frame_edge        = 1'b0;

        if (load) begin
            pending_nxt       = load_data;
            pending_valid_nxt = 1'b1;
        end

        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = '0;
                end
                BLANK: begin
                    if (blank_end) state_nxt = SHOW;
                end
                SHOW: begin
                    if (slot_end) begin
                        state_nxt = BLANK;
                        if (idx == IDX_LAST) begin
                            idx_nxt    = '0;
                            frame_edge = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // A load landing on the frame boundary bypasses the pending buffer.
        if (frame_edge) begin
            if (load) begin
                active_nxt        = load_data;
                pending_valid_nxt = 1'b0;
            end else if (pending_valid) begin
                active_nxt        = pending;
                pending_valid_nxt = 1'b0;
            end
        end
    end

    assign show_nxt   = (state_nxt == SHOW);
    assign sel_onehot = NDIG'(1) << idx_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            anode_n       <= '1;
            digit_code    <= '0;
            blank         <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            active        <= active_nxt;
            pending       <= pending_nxt;
            pending_valid <= pending_valid_nxt;
            anode_n       <= show_nxt ? ~sel_onehot : '1;
            digit_code    <= show_nxt ? digit_at(MAX_VEC_W'(active_nxt), 32'(idx_nxt)) : '0;
            blank         <= !show_nxt;
            frame_done    <= frame_edge;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed scan/load/enable/reset scenarios plus random traffic vs a position-based model.
module tb_seg_scan_mux;

    localparam int NDIG      = 2;
    localparam int PRESCALE  = 4;
    localparam int BLANK_CYC = 1;
    localparam int DW        = 3;
    localparam int VW        = NDIG * DW;
    localparam int FRAME     = NDIG * PRESCALE;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            load;
    logic [VW-1:0]   load_data;
    logic [DW-1:0]   digit_code;
    logic [NDIG-1:0] anode_n;
    logic            blank;
    logic            frame_done;

    int total = 0;
    int bad   = 0;

    // Reference model: scan position counted from the start of scanning.
    bit            m_run;
    int            m_p;
    bit            m_fd;
    logic [VW-1:0] m_active;
    logic [VW-1:0] exp_q[$];

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NDIG      (NDIG),
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_data  (load_data),
        .digit_code (digit_code),
        .anode_n    (anode_n),
        .blank      (blank),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_p      = 0;
        m_fd     = 1'b0;
        m_active = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit en, input bit ld, input logic [VW-1:0] data);
        bit boundary;
        if (!en) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_p   = 0;
        end else begin
            m_p++;
        end
        boundary = m_run && (m_p > 0) && ((m_p % FRAME) == 0);
        if (boundary) begin
            if (ld) begin
                m_active = data;
                exp_q.delete();
            end else if (exp_q.size() > 0) begin
                m_active = exp_q[$];
                exp_q.delete();
            end
        end else if (ld) begin
            exp_q.push_back(data);
        end
        m_fd = boundary;
    endtask

    task automatic compare_outputs();
        bit              show;
        int              d;
        logic [NDIG-1:0] exp_an;
        logic [DW-1:0]   exp_dc;
        show   = m_run && ((m_p % PRESCALE) >= BLANK_CYC);
        d      = (m_p / PRESCALE) % NDIG;
        exp_an = '1;
        exp_dc = '0;
        if (show) begin
            exp_an[d] = 1'b0;
            exp_dc    = m_active[d*DW +: DW];
        end
        check("anode_n", 32'(anode_n), 32'(exp_an));
        check("digit_code", 32'(digit_code), 32'(exp_dc));
        check("blank", 32'(blank), 32'(!show));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("pending_valid", 32'(dut.pending_valid), 32'(exp_q.size() != 0));
    endtask

    // Called right after a falling edge; inputs settle before the next rising edge.
    task automatic cycle(input bit en, input bit ld, input logic [VW-1:0] data);
        enable    = en;
        load      = ld;
        load_data = data;
        @(posedge clk);
        model_step(en, ld, data);
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        logic [NDIG-1:0] an_tbl[9];
        logic [VW-1:0]   d;
        bit              ld;
        an_tbl = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};

        reset     = 1'b1;
        enable    = 1'b0;
        load      = 1'b0;
        load_data = '0;
        model_reset();
        #1;
        check("rst_anode_n", 32'(anode_n), 32'h3);
        check("rst_digit_code", 32'(digit_code), 32'h0);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_pending_valid", 32'(dut.pending_valid), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        repeat (2) cycle(1'b0, 1'b0, '0);

        // First frame, with a boundary-coincident load installing {5,2}.
        for (int k = 0; k <= 8; k++) begin
            cycle(1'b1, k == 8, (k == 8) ? {3'd5, 3'd2} : '0);
            check("s1_anode_seq", 32'(anode_n), 32'(an_tbl[k]));
            check("s1_frame_done", 32'(frame_done), 32'(k == 8));
        end
        check("s1_boundary_pv", 32'(dut.pending_valid), 32'h0);

        // Mid-frame load, then two loads in one frame.
        for (int k = 9; k <= 40; k++) begin
            ld = 1'b0;
            d  = '0;
            case (k)
                10: begin ld = 1'b1; d = {3'd7, 3'd1}; end
                26: begin ld = 1'b1; d = {3'd1, 3'd1}; end
                30: begin ld = 1'b1; d = {3'd3, 3'd4}; end
                default: ;
            endcase
            cycle(1'b1, ld, d);
            case (k)
                11: check("s2_d0_old", 32'(digit_code), 32'd2);
                15: check("s2_d1_old", 32'(digit_code), 32'd5);
                18: check("s2_d0_new", 32'(digit_code), 32'd1);
                22: check("s2_d1_new", 32'(digit_code), 32'd7);
                34: check("s3_d0_last", 32'(digit_code), 32'd4);
                38: check("s3_d1_last", 32'(digit_code), 32'd3);
                default: ;
            endcase
        end

        // Drop enable while digit 1 is shown, then restart.
        for (int k = 41; k <= 46; k++) cycle(1'b1, 1'b0, '0);
        check("s4_showing_d1", 32'(anode_n), 32'h1);
        cycle(1'b0, 1'b0, '0);
        check("s4_off_anode", 32'(anode_n), 32'h3);
        check("s4_off_blank", 32'(blank), 32'h1);
        check("s4_off_fd", 32'(frame_done), 32'h0);
        cycle(1'b1, 1'b0, '0);
        check("s4_restart_blank", 32'(anode_n), 32'h3);
        cycle(1'b1, 1'b0, '0);
        check("s4_restart_d0", 32'(anode_n), 32'h2);
        check("s4_restart_code", 32'(digit_code), 32'd4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0,
                  VW'($urandom_range(0, (1 << VW) - 1)));
        end

        // Install {6,3}, then hit reset mid-slot while digit 0 shows.
        cycle(1'b0, 1'b0, '0);
        for (int k = 0; k <= 8; k++) cycle(1'b1, k == 8, (k == 8) ? {3'd6, 3'd3} : '0);
        cycle(1'b1, 1'b0, '0);
        check("s5_pre_code", 32'(digit_code), 32'd3);
        cycle(1'b1, 1'b0, '0);
        #2;
        reset = 1'b1;
        #1;
        check("s5_async_anode", 32'(anode_n), 32'h3);
        check("s5_async_code", 32'(digit_code), 32'h0);
        check("s5_async_blank", 32'(blank), 32'h1);
        check("s5_async_fd", 32'(frame_done), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (k == 2) check("s5_cleared_d0", 32'(digit_code), 32'h0);
            if (k == 6) check("s5_cleared_d1", 32'(digit_code), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
